voter_5: RTL and testbench

//   Five-input majority voter. Counts asserted votes on a 5-bit ballot bus and

---
 rtl/voter_5_if.sv | 19 +
 rtl/voter_5.sv | 36 +++
 tb/tb_voter_5.sv | 121 ++++++++++++
 3 files changed

// File: rtl/voter_5_if.sv
// Ballot bus between the switch/DIP input stage and the voter: raw vote bits
// in, registered vote count and majority flag out.
interface voter_5_if;
  logic [4:0] Datain;
  logic [2:0] count;
  logic       resVoter;

  modport master (
    output Datain,
    input  count,
    input  resVoter
  );

  modport slave (
    input  Datain,
    output count,
    output resVoter
  );
endinterface

// File: rtl/voter_5.sv
// Five-input majority voter: registers the number of yes votes and whether
// that number reaches the majority threshold, both from the same sample.
module voter_5 #(
  parameter int N_VOTERS  = 5,
  parameter int THRESHOLD = 3
) (
  input  logic      clk,
  input  logic      rst,
  voter_5_if.slave  bus
);

  localparam logic [2:0] THRESH = 3'(THRESHOLD);

  logic [2:0] votes;
  logic       majority;

  // Five bits can sum to at most 5, so a 3-bit accumulator never overflows.
  always_comb begin
    votes = 3'd0;
    for (int i = 0; i < N_VOTERS; i++) begin
      votes = votes + {2'b00, bus.Datain[i]};
    end
    majority = (votes >= THRESH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.count    <= 3'd0;
      bus.resVoter <= 1'b0;
    end else begin
      bus.count    <= votes;
      bus.resVoter <= majority;
    end
  end

endmodule

// File: tb/tb_voter_5.sv
// Directed bench for voter_5: reset behaviour, full ballot sweep, boundary
// ballots, permutations, one-cycle latency and mid-stream reset.
module tb_voter_5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  voter_5_if vif ();

  voter_5 dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a ballot on the falling edge and return just after the next rising edge.
  task automatic apply_stimulus(input logic [4:0] ballot);
    @(negedge clk);
    vif.Datain = ballot;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [2:0] exp_count,
                              input logic exp_res);
    total++;
    assert (vif.count === exp_count) else begin
      bad++;
      $error("[TB] FAIL %s count: observed=%0d expected=%0d", tag, vif.count, exp_count);
    end
    total++;
    assert (vif.resVoter === exp_res) else begin
      bad++;
      $error("[TB] FAIL %s resVoter: observed=%0b expected=%0b", tag, vif.resVoter, exp_res);
    end
  endtask

  initial begin
    logic [4:0] ballot;
    int         ones;
    total = 0;
    bad   = 0;

    // Reset held with all votes asserted, checked before the first clock edge.
    rst        = 1'b1;
    vif.Datain = 5'b11111;
    #2;
    check_output("reset_no_edge", 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check_output("reset_held_edge", 3'd0, 1'b0);

    // Release reset on a falling edge; first rising edge loads the current ballot.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("first_after_reset", 3'd5, 1'b1);

    for (int v = 0; v < 32; v++) begin
      ballot = 5'(v);
      ones   = $countones(ballot);
      apply_stimulus(ballot);
      check_output($sformatf("sweep_%0d", v), 3'(ones), ones >= 3);
    end

    apply_stimulus(5'b00111);
    check_output("ex_00111", 3'd3, 1'b1);
    apply_stimulus(5'b00011);
    check_output("bound_00011", 3'd2, 1'b0);
    apply_stimulus(5'b11111);
    check_output("bound_11111", 3'd5, 1'b1);
    apply_stimulus(5'b00000);
    check_output("bound_00000", 3'd0, 1'b0);

    apply_stimulus(5'b10101);
    check_output("perm_10101", 3'd3, 1'b1);
    apply_stimulus(5'b01110);
    check_output("perm_01110", 3'd3, 1'b1);
    apply_stimulus(5'b11100);
    check_output("perm_11100", 3'd3, 1'b1);

    // Outputs must still show the previous ballot until the next rising edge.
    apply_stimulus(5'b00000);
    check_output("lat_00000", 3'd0, 1'b0);
    apply_stimulus(5'b11000);
    check_output("lat_11000", 3'd2, 1'b0);
    @(negedge clk);
    vif.Datain = 5'b11001;
    #1;
    check_output("lat_before_edge", 3'd2, 1'b0);
    @(posedge clk);
    #1;
    check_output("lat_11001", 3'd3, 1'b1);

    // Asynchronous reset in the middle of a cycle clears outputs without an edge.
    apply_stimulus(5'b11110);
    check_output("pre_reset_4", 3'd4, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_reset", 3'd0, 1'b0);
    @(negedge clk);
    vif.Datain = 5'b01011;
    #1;
    check_output("mid_reset_held", 3'd0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("reload_after_reset", 3'd3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
